// File: rtl/peripheral_uart_fifo.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, runtime baud divisor, sticky error flags and FIFO levels.
// Optional level interrupt when UART_FIFO_IRQ_EN is defined; otherwise irq is tied low.
module peripheral_uart_fifo #(
   parameter int CLK_FREQ = 25000000,
   parameter int BAUD     = 115200,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16,
   parameter int DIV_W    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] d_in,
   input  logic        cs,
   input  logic [4:0]  addr,
   input  logic        wr,
   input  logic        rd,
   output logic [31:0] d_out,
   output logic        uart_tx,
   input  logic        uart_rx,
   output logic        ledout,
   output logic        irq
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FREQ / BAUD);
   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

   localparam logic [4:0] A_DATA  = 5'h00;
   localparam logic [4:0] A_STAT  = 5'h04;
   localparam logic [4:0] A_DIV   = 5'h08;
   localparam logic [4:0] A_CTRL  = 5'h0C;
   localparam logic [4:0] A_LEVEL = 5'h10;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------- bus decode and control registers ----------------
   logic             w_wr, w_rd, w_flush, w_stat_wr;
   logic [DIV_W-1:0] r_div, w_div_eff;
   logic [4:0]       r_ctrl;
   logic             r_tx_ovf, r_rx_ovr, r_frame_err;
   logic             w_unused_din;

   assign w_wr      = cs & wr;
   assign w_rd      = cs & rd;
   assign w_stat_wr = w_wr && (addr == A_STAT);
   assign w_flush   = w_wr && (addr == A_CTRL) && d_in[5];
   assign w_div_eff = (r_div < DIV_MIN) ? DIV_MIN : r_div;
   assign ledout    = r_ctrl[2];
   assign w_unused_din = ^d_in;

   // ---------------- TX FIFO ----------------
   logic [7:0]       r_tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
   logic [TX_AW:0]   r_tx_count;
   logic             w_tx_wr, w_tx_pop, w_tx_do_pop, w_tx_do_push;
   logic             w_tx_empty, w_tx_full, w_tx_ovf_set;
   logic [7:0]       w_tx_head;

   assign w_tx_wr      = w_wr && (addr == A_DATA);
   assign w_tx_empty   = (r_tx_count == '0);
   assign w_tx_full    = (r_tx_count == (TX_AW+1)'(TX_DEPTH));
   assign w_tx_head    = r_tx_mem[r_tx_rp];
   assign w_tx_do_pop  = w_tx_pop && !w_tx_empty;
   // A full FIFO still accepts a write when the engine pops in the same cycle.
   assign w_tx_do_push = w_tx_wr && (!w_tx_full || w_tx_do_pop);
   assign w_tx_ovf_set = w_tx_wr && w_tx_full && !w_tx_do_pop;

   always_ff @(posedge clk) begin
      if (w_tx_do_push) r_tx_mem[r_tx_wp] <= d_in[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_tx_wp    <= '0;
         r_tx_rp    <= '0;
         r_tx_count <= '0;
      end else begin
         if (w_tx_do_push) r_tx_wp <= r_tx_wp + TX_AW'(1);
         if (w_tx_do_pop)  r_tx_rp <= r_tx_rp + TX_AW'(1);
         case ({w_tx_do_push, w_tx_do_pop})
            2'b10:   r_tx_count <= r_tx_count + (TX_AW+1)'(1);
            2'b01:   r_tx_count <= r_tx_count - (TX_AW+1)'(1);
            default: r_tx_count <= r_tx_count;
         endcase
      end
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]       r_rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
   logic [RX_AW:0]   r_rx_count;
   logic             w_rx_push, w_rx_do_pop, w_rx_do_push;
   logic             w_rx_empty, w_rx_full, w_rx_ovr_set;
   logic [7:0]       w_rx_head;
   logic [7:0]       r_rx_shift;

   assign w_rx_empty   = (r_rx_count == '0);
   assign w_rx_full    = (r_rx_count == (RX_AW+1)'(RX_DEPTH));
   assign w_rx_head    = r_rx_mem[r_rx_rp];
   assign w_rx_do_pop  = w_rd && (addr == A_DATA) && !w_rx_empty;
   assign w_rx_do_push = w_rx_push && (!w_rx_full || w_rx_do_pop);
   assign w_rx_ovr_set = w_rx_push && w_rx_full && !w_rx_do_pop && !w_flush;

   always_ff @(posedge clk) begin
      if (w_rx_do_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
   end

   always_ff @(posedge clk) begin
      if (rst || w_flush) begin
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
         r_rx_count <= '0;
      end else begin
         if (w_rx_do_push) r_rx_wp <= r_rx_wp + RX_AW'(1);
         if (w_rx_do_pop)  r_rx_rp <= r_rx_rp + RX_AW'(1);
         case ({w_rx_do_push, w_rx_do_pop})
            2'b10:   r_rx_count <= r_rx_count + (RX_AW+1)'(1);
            2'b01:   r_rx_count <= r_rx_count - (RX_AW+1)'(1);
            default: r_rx_count <= r_rx_count;
         endcase
      end
   end

   // ---------------- TX engine ----------------
   tx_state_t        r_tx_state, w_tx_state_nxt;
   logic [DIV_W-1:0] r_tx_cnt, w_tx_cnt_nxt, r_tx_div, w_tx_div_nxt;
   logic [2:0]       r_tx_bit, w_tx_bit_nxt;
   logic [7:0]       r_tx_shift, w_tx_shift_nxt;
   logic             r_uart_tx, w_tx_line_nxt, w_tx_bit_end, w_tx_busy;

   assign w_tx_busy = (r_tx_state != TX_IDLE);
   assign uart_tx   = r_uart_tx;

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_cnt_nxt   = r_tx_cnt + DIV_W'(1);
      w_tx_div_nxt   = r_tx_div;
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_pop       = 1'b0;
      w_tx_line_nxt  = 1'b1;
      w_tx_bit_end   = (r_tx_cnt == r_tx_div - DIV_W'(1));
      case (r_tx_state)
         TX_IDLE: begin
            w_tx_cnt_nxt = '0;
            if (r_ctrl[0] && !w_tx_empty) begin
               w_tx_pop       = 1'b1;
               w_tx_state_nxt = TX_START;
               w_tx_shift_nxt = w_tx_head;
               w_tx_div_nxt   = w_div_eff;
               w_tx_bit_nxt   = '0;
            end
         end
         TX_START: if (w_tx_bit_end) begin
            w_tx_cnt_nxt   = '0;
            w_tx_state_nxt = TX_DATA;
         end
         TX_DATA: if (w_tx_bit_end) begin
            w_tx_cnt_nxt   = '0;
            w_tx_shift_nxt = {1'b1, r_tx_shift[7:1]};
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) w_tx_state_nxt = TX_STOP;
         end
         TX_STOP: if (w_tx_bit_end) begin
            w_tx_cnt_nxt   = '0;
            w_tx_state_nxt = TX_IDLE;
         end
         default: w_tx_state_nxt = TX_IDLE;
      endcase
      // The line is registered from the next state so it never glitches.
      case (w_tx_state_nxt)
         TX_START: w_tx_line_nxt = 1'b0;
         TX_DATA:  w_tx_line_nxt = w_tx_shift_nxt[0];
         default:  w_tx_line_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_div   <= DIV_MIN;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_uart_tx  <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_tx_div   <= w_tx_div_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_uart_tx  <= w_tx_line_nxt;
      end
   end

   // ---------------- RX engine ----------------
   rx_state_t        r_rx_state, w_rx_state_nxt;
   logic [DIV_W-1:0] r_rx_cnt, w_rx_cnt_nxt, r_rx_div, w_rx_div_nxt;
   logic [2:0]       r_rx_bit, w_rx_bit_nxt;
   logic [7:0]       w_rx_shift_nxt;
   logic             r_rx_s1, r_rx_s2, r_rx_prev, w_rx_fall, w_rx_ferr_set, w_rx_full_bit;

   assign w_rx_fall     = r_rx_prev & ~r_rx_s2;
   assign w_rx_full_bit = (r_rx_cnt == r_rx_div - DIV_W'(1));

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt + DIV_W'(1);
      w_rx_div_nxt   = r_rx_div;
      w_rx_bit_nxt   = r_rx_bit;
      w_rx_shift_nxt = r_rx_shift;
      w_rx_push      = 1'b0;
      w_rx_ferr_set  = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            w_rx_cnt_nxt = '0;
            if (r_ctrl[1] && w_rx_fall) begin
               w_rx_state_nxt = RX_START;
               w_rx_div_nxt   = w_div_eff;
            end
         end
         // Mid-start sample; a line already back high was only a glitch.
         RX_START: if (r_rx_cnt == (r_rx_div >> 1) - DIV_W'(1)) begin
            w_rx_cnt_nxt = '0;
            w_rx_bit_nxt = '0;
            w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (w_rx_full_bit) begin
            w_rx_cnt_nxt   = '0;
            w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
            w_rx_bit_nxt   = r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
         end
         RX_STOP: if (w_rx_full_bit) begin
            w_rx_cnt_nxt   = '0;
            w_rx_state_nxt = RX_IDLE;
            w_rx_push      = r_rx_s2;
            w_rx_ferr_set  = ~r_rx_s2;
         end
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_div   <= DIV_MIN;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_s1    <= uart_rx;
         r_rx_s2    <= r_rx_s1;
         r_rx_prev  <= r_rx_s2;
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_div   <= w_rx_div_nxt;
         r_rx_bit   <= w_rx_bit_nxt;
         r_rx_shift <= w_rx_shift_nxt;
      end
   end

   // ---------------- registers and sticky flags ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl      <= 5'h03;
         r_div       <= DIV_RST;
         r_tx_ovf    <= 1'b0;
         r_rx_ovr    <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_wr && (addr == A_DIV))  r_div  <= d_in[DIV_W-1:0];
         if (w_wr && (addr == A_CTRL)) r_ctrl <= d_in[4:0];
         // Clearing wins over a set arriving in the same cycle.
         if (w_stat_wr && d_in[7])  r_tx_ovf <= 1'b0;
         else if (w_tx_ovf_set)     r_tx_ovf <= 1'b1;
         if (w_stat_wr && d_in[6])  r_rx_ovr <= 1'b0;
         else if (w_rx_ovr_set)     r_rx_ovr <= 1'b1;
         if (w_stat_wr && d_in[5])  r_frame_err <= 1'b0;
         else if (w_rx_ferr_set)    r_frame_err <= 1'b1;
      end
   end

   always_comb begin
      d_out = '0;
      if (cs) begin
         case (addr)
            A_DATA:  d_out = {24'b0, (w_rx_empty ? 8'h00 : w_rx_head)};
            A_STAT:  d_out = {24'b0, r_tx_ovf, r_rx_ovr, r_frame_err, w_tx_full,
                              w_tx_empty, w_rx_full, !w_rx_empty, w_tx_busy};
            A_DIV:   d_out = 32'(r_div);
            A_CTRL:  d_out = {27'b0, r_ctrl};
            A_LEVEL: d_out = {16'(r_rx_count), 16'(r_tx_count)};
            default: d_out = '0;
         endcase
      end
   end

`ifdef UART_FIFO_IRQ_EN
   logic r_irq;
   always_ff @(posedge clk) begin
      if (rst) r_irq <= 1'b0;
      else     r_irq <= (r_ctrl[3] & !w_rx_empty) | (r_ctrl[4] & w_tx_empty & ~w_tx_busy)
                        | r_rx_ovr | r_frame_err;
   end
   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_uart_fifo.sv
// Self-checking bench for peripheral_uart_fifo: TX waveform, loopback, FIFO limits, RX errors, reset, irq.
module tb_peripheral_uart_fifo;
   localparam logic [4:0] A_DATA  = 5'h00;
   localparam logic [4:0] A_STAT  = 5'h04;
   localparam logic [4:0] A_DIV   = 5'h08;
   localparam logic [4:0] A_CTRL  = 5'h0C;
   localparam logic [4:0] A_LEVEL = 5'h10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [31:0] d_in = '0;
   logic [4:0]  addr = '0;
   logic [31:0] d_out;
   logic        uart_tx, uart_rx, ledout, irq;
   logic        loopback = 1'b0;
   logic        rx_drv = 1'b1;

   logic [7:0]  exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;

   assign uart_rx = loopback ? uart_tx : rx_drv;

   peripheral_uart_fifo dut (
      .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .wr(wr), .rd(rd),
      .d_out(d_out), .uart_tx(uart_tx), .uart_rx(uart_rx), .ledout(ledout), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0; d_in = '0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = a;
      #1 d = d_out;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit, input int div);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (div) @(negedge clk);
      end
      rx_drv = stop_bit;
      repeat (div) @(negedge clk);
      rx_drv = 1'b1;
      repeat (div) @(negedge clk);
   endtask

   task automatic wait_rx_level(input int n, input int max_cyc);
      cs = 1'b1; addr = A_LEVEL;
      #1;
      for (int i = 0; i < max_cyc && d_out[31:16] != 16'(n); i++) @(negedge clk);
      cs = 1'b0;
   endtask

   task automatic wait_tx_idle(input int max_cyc);
      cs = 1'b1; addr = A_STAT;
      #1;
      for (int i = 0; i < max_cyc && d_out[0] !== 1'b0; i++) @(negedge clk);
      cs = 1'b0;
   endtask

   initial begin
      logic [31:0] rd_val;
      logic [7:0]  tx_byte;
      logic [7:0]  b;
      logic        exp_bit;
      int          wait_cycles, low_cycles;
      logic [7:0]  t2_bytes [3];
      t2_bytes = '{8'h00, 8'h55, 8'hFF};

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_val("rst_uart_tx", 32'(uart_tx), 32'h1);
      check_val("rst_ledout", 32'(ledout), 32'h0);
      check_val("rst_irq", 32'(irq), 32'h0);
      bus_read(A_DIV, rd_val);   check_val("rst_div", rd_val, 32'd217);
      bus_read(A_CTRL, rd_val);  check_val("rst_ctrl", rd_val, 32'h03);
      bus_read(A_STAT, rd_val);  check_val("rst_status", rd_val, 32'h08);
      bus_read(A_LEVEL, rd_val); check_val("rst_level", rd_val, 32'h0);
      bus_read(A_DATA, rd_val);  check_val("rst_data_empty", rd_val, 32'h0);

      // Test 1: TX waveform of 0xA5 at DIV 8
      tx_byte = 8'hA5;
      bus_write(A_DIV, 32'd8);
      bus_write(A_DATA, 32'(tx_byte));
      cs = 1'b1; addr = A_STAT;
      wait_cycles = 0;
      while (uart_tx !== 1'b0 && wait_cycles < 20) begin
         @(negedge clk);
         wait_cycles++;
      end
      check_val("t1_start_latency", 32'(wait_cycles), 32'd1);
      for (int k = 0; k < 80; k++) begin
         if (k < 8)       exp_bit = 1'b0;
         else if (k < 72) exp_bit = tx_byte[(k - 8) / 8];
         else             exp_bit = 1'b1;
         check_val($sformatf("t1_line_%0d", k), 32'(uart_tx), 32'(exp_bit));
         check_val($sformatf("t1_busy_%0d", k), 32'(d_out[0]), 32'h1);
         @(negedge clk);
      end
      check_val("t1_line_idle", 32'(uart_tx), 32'h1);
      check_val("t1_busy_end", 32'(d_out[0]), 32'h0);
      cs = 1'b0;

      // Test 1b: DIV below 4 acts as 4
      bus_write(A_DIV, 32'd1);
      bus_write(A_DATA, 32'h01);
      wait_cycles = 0;
      while (uart_tx !== 1'b0 && wait_cycles < 20) begin
         @(negedge clk);
         wait_cycles++;
      end
      low_cycles = 0;
      while (uart_tx === 1'b0 && low_cycles < 40) begin
         @(negedge clk);
         low_cycles++;
      end
      check_val("t1_min_div_start_len", 32'(low_cycles), 32'd4);
      wait_tx_idle(200);
      bus_read(A_STAT, rd_val); check_val("t1_min_div_idle", 32'(rd_val[0]), 32'h0);

      // Test 2: loopback three bytes
      bus_write(A_DIV, 32'd8);
      loopback = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_write(A_DATA, 32'(t2_bytes[i]));
         exp_q.push_back(t2_bytes[i]);
      end
      wait_rx_level(3, 1500);
      repeat (20) @(negedge clk);
      loopback = 1'b0;
      bus_read(A_LEVEL, rd_val); check_val("t2_level", rd_val, 32'h0003_0000);
      bus_read(A_STAT, rd_val);  check_val("t2_status", rd_val, 32'h0A);
      for (int i = 0; i < 3; i++) begin
         bus_read(A_DATA, rd_val);
         check_val($sformatf("t2_data_%0d", i), rd_val, 32'(exp_q.pop_front()));
      end
      bus_read(A_STAT, rd_val);  check_val("t2_status_drained", rd_val, 32'h08);

      // Test 3: TX overflow with tx_en off, clear, led, flush
      bus_write(A_CTRL, 32'h06);
      check_val("t3_ledout_on", 32'(ledout), 32'h1);
      for (int i = 0; i < 17; i++) bus_write(A_DATA, 32'($urandom_range(0, 255)));
      bus_read(A_STAT, rd_val);  check_val("t3_status_full_ovf", rd_val, 32'h90);
      bus_read(A_LEVEL, rd_val); check_val("t3_level_tx16", rd_val, 32'h0000_0010);
      bus_write(A_STAT, 32'h80);
      bus_read(A_STAT, rd_val);  check_val("t3_status_ovf_clr", rd_val, 32'h10);
      bus_write(A_CTRL, 32'h22);
      bus_read(A_LEVEL, rd_val); check_val("t3_level_flushed", rd_val, 32'h0);
      bus_read(A_CTRL, rd_val);  check_val("t3_ctrl_flush_reads0", rd_val, 32'h02);
      check_val("t3_ledout_off", 32'(ledout), 32'h0);
      bus_read(A_STAT, rd_val);  check_val("t3_status_flushed", rd_val, 32'h08);
      bus_write(A_CTRL, 32'h03);

      // Test 4: frame error, then RX overrun
      send_rx_frame(8'h5A, 1'b0, 8);
      bus_read(A_STAT, rd_val);  check_val("t4_frame_err", rd_val, 32'h28);
      bus_read(A_LEVEL, rd_val); check_val("t4_level_after_ferr", rd_val, 32'h0);
      bus_write(A_STAT, 32'h20);
      bus_read(A_STAT, rd_val);  check_val("t4_ferr_clr", rd_val, 32'h08);
      for (int i = 0; i < 17; i++) begin
         b = 8'($urandom_range(0, 255));
         send_rx_frame(b, 1'b1, 8);
         if (i < 16) exp_q.push_back(b);
      end
      bus_read(A_STAT, rd_val);  check_val("t4_status_ovr", rd_val, 32'h4E);
      bus_read(A_LEVEL, rd_val); check_val("t4_level_rx16", rd_val, 32'h0010_0000);
      for (int i = 0; i < 16; i++) begin
         bus_read(A_DATA, rd_val);
         check_val($sformatf("t4_data_%0d", i), rd_val, 32'(exp_q.pop_front()));
      end
      bus_write(A_STAT, 32'h40);
      bus_read(A_STAT, rd_val);  check_val("t4_ovr_clr", rd_val, 32'h08);

      // Test 5: start glitch, then reset mid TX frame
      bus_write(A_DIV, 32'd16);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (60) @(negedge clk);
      bus_read(A_LEVEL, rd_val); check_val("t5_glitch_level", rd_val, 32'h0);
      bus_read(A_STAT, rd_val);  check_val("t5_glitch_status", rd_val, 32'h08);
      for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'h3C);
      wait_cycles = 0;
      while (uart_tx !== 1'b0 && wait_cycles < 20) begin
         @(negedge clk);
         wait_cycles++;
      end
      repeat (5) @(negedge clk);
      check_val("t5_pre_rst_line", 32'(uart_tx), 32'h0);
      rst = 1'b1; cs = 1'b1; addr = A_LEVEL;
      @(negedge clk);
      check_val("t5_rst_line", 32'(uart_tx), 32'h1);
      check_val("t5_rst_level", d_out, 32'h0);
      addr = A_STAT;
      #1 check_val("t5_rst_status", d_out, 32'h08);
      rst = 1'b0; cs = 1'b0;
      bus_read(A_DIV, rd_val);   check_val("t5_rst_div", rd_val, 32'd217);

      // Test 6: interrupt on RX data
      bus_write(A_DIV, 32'd8);
      bus_write(A_CTRL, 32'h0B);
      exp_q.push_back(8'hC3);
      send_rx_frame(8'hC3, 1'b1, 8);
      repeat (2) @(negedge clk);
`ifdef UART_FIFO_IRQ_EN
      check_val("t6_irq_set", 32'(irq), 32'h1);
`else
      check_val("t6_irq_tied", 32'(irq), 32'h0);
`endif
      bus_read(A_DATA, rd_val);  check_val("t6_data", rd_val, 32'(exp_q.pop_front()));
      @(negedge clk);
      check_val("t6_irq_clear", 32'(irq), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
